// File: rtl/call_ret_ctrl_pkg.sv
// Shared encodings for the call/return sequencer: op codes and FSM states.
package call_ret_ctrl_pkg;

  // Control-flow operation presented with op_valid.
  typedef enum logic [1:0] {
    OP_STEP = 2'b00,
    OP_JUMP = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  // IDLE accepts ops; ISSUE is the cycle the stack samples en/c/push;
  // SETTLE lets the stack's peek reflect its new top before the next op.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISSUE  = 2'b01,
    SETTLE = 2'b10
  } state_e;

endpackage

// File: rtl/call_ret_ctrl.sv
// Program counter and call/return sequencer in front of a return-address stack.
// Tracks stack occupancy locally (the stack has no full/empty) and raises
// sticky overflow/underflow flags. Every output comes straight from a register.
module call_ret_ctrl
  import call_ret_ctrl_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [width-1:0] target,
  output logic             ready,
  output logic [width-1:0] pc,
  output logic             stk_c,
  output logic             stk_en,
  output logic [width-1:0] stk_push,
  input  logic [width-1:0] stk_peek,
  output logic [depth:0]   level,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned        CAP_INT = 1 << depth;
  localparam logic [depth:0]     CAP     = CAP_INT[depth:0];
  localparam logic [depth:0]     LVL_ONE = (depth + 1)'(1);
  localparam logic [width-1:0]   PC_ONE  = width'(1);

  state_e             state_q, state_d;
  logic [width-1:0]   pc_q, pc_d;
  logic               stk_c_q, stk_c_d;
  logic               stk_en_q, stk_en_d;
  logic [width-1:0]   stk_push_q, stk_push_d;
  logic [depth:0]     level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  op_e                op_s;
  logic [width-1:0]   pc_inc;

  assign op_s   = op_e'(op);
  assign pc_inc = pc_q + PC_ONE;

  // Next-state and next-output decode for the FSM and PC datapath.
  always_comb begin
    // NOTE: every _d gets a hold/default value first so no path through the
    // case statements leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    stk_c_d    = stk_c_q;
    stk_en_d   = 1'b0;
    stk_push_d = stk_push_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          unique case (op_s)
            OP_STEP: pc_d = pc_inc;
            OP_JUMP: pc_d = target;
            OP_CALL: begin
              pc_d = target;
              if (level_q != CAP) begin
                stk_en_d   = 1'b1;
                stk_c_d    = 1'b1;
                stk_push_d = pc_inc;
                level_d    = level_q + LVL_ONE;
                state_d    = ISSUE;
              end else begin
                ovf_d = 1'b1;
              end
            end
            OP_RET: begin
              if (level_q != '0) begin
                // The stack has been idle at least one cycle, so peek is its top.
                pc_d     = stk_peek;
                stk_en_d = 1'b1;
                stk_c_d  = 1'b0;
                level_d  = level_q - LVL_ONE;
                state_d  = ISSUE;
              end else begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ISSUE:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; clear wins over everything, including ISSUE/SETTLE.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (!clr) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      stk_c_q    <= 1'b0;
      stk_en_q   <= 1'b0;
      stk_push_q <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      stk_c_q    <= stk_c_d;
      stk_en_q   <= stk_en_d;
      stk_push_q <= stk_push_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign pc       = pc_q;
  assign stk_c    = stk_c_q;
  assign stk_en   = stk_en_q;
  assign stk_push = stk_push_q;
  assign level    = level_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Scoreboard bench for call_ret_ctrl with a two-entry return-address stack model.
// The driver pushes the hand-computed expected output snapshot for each edge;
// the monitor pops and compares one snapshot just after every rising edge.
module tb_call_ret_ctrl;
  import call_ret_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       op_valid = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] target = 8'h00;
  logic       ready;
  logic [7:0] pc;
  logic       stk_c;
  logic       stk_en;
  logic [7:0] stk_push;
  logic [7:0] stk_peek;
  logic [1:0] level;
  logic       ovf;
  logic       unf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  call_ret_ctrl #(.width(8), .depth(1)) dut (
    .clk      (clk),
    .clr      (clr),
    .op_valid (op_valid),
    .op       (op),
    .target   (target),
    .ready    (ready),
    .pc       (pc),
    .stk_c    (stk_c),
    .stk_en   (stk_en),
    .stk_push (stk_push),
    .stk_peek (stk_peek),
    .level    (level),
    .ovf      (ovf),
    .unf      (unf)
  );

  // Return-address stack: push on en&&c, pop on en&&!c, shares clr.
  logic [7:0] stk_mem [2];
  logic [1:0] stk_sp;
  logic       top_idx;
  assign top_idx  = stk_sp[0] - 1'b1;
  assign stk_peek = stk_mem[top_idx];

  // Stack model state update.
  always_ff @(posedge clk) begin
    if (!clr) begin
      stk_sp     <= 2'd0;
      stk_mem[0] <= 8'h00;
      stk_mem[1] <= 8'h00;
    end else if (stk_en) begin
      if (stk_c) begin
        if (stk_sp < 2'd2) begin
          stk_mem[stk_sp[0]] <= stk_push;
          stk_sp             <= stk_sp + 2'd1;
        end
      end else if (stk_sp != 2'd0) begin
        stk_sp <= stk_sp - 2'd1;
      end
    end
  end

  typedef struct packed {
    logic [7:0] pc;
    logic       rdy;
    logic       en;
    logic       c;
    logic [7:0] push;
    logic [1:0] lvl;
    logic       ovf;
    logic       unf;
    logic       chk_peek;
    logic [7:0] peek;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(input logic [7:0] p, input logic r, input logic e,
                              input logic c, input logic [7:0] pu, input logic [1:0] l,
                              input logic o, input logic u);
    exp_t x;
    x.pc = p; x.rdy = r; x.en = e; x.c = c; x.push = pu; x.lvl = l;
    x.ovf = o; x.unf = u; x.chk_peek = 1'b0; x.peek = 8'h00;
    return x;
  endfunction

  function automatic exp_t with_peek(input exp_t e, input logic [7:0] p);
    exp_t x;
    x = e;
    x.chk_peek = 1'b1;
    x.peek = p;
    return x;
  endfunction

  // One cycle of stimulus plus the snapshot expected after the coming rising edge.
  task automatic cyc(input logic r, input logic v, input logic [1:0] o,
                     input logic [7:0] t, input exp_t e);
    @(negedge clk);
    clr = r; op_valid = v; op = o; target = t;
    exp_q.push_back(e);
  endtask

  // Monitor: compares the DUT against each queued snapshot 1 time unit after the edge.
  initial begin
    int n;
    exp_t e;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n++;
        checks++;
        if (pc !== e.pc || ready !== e.rdy || stk_en !== e.en || stk_c !== e.c ||
            stk_push !== e.push || level !== e.lvl || ovf !== e.ovf || unf !== e.unf) begin
          failures++;
          $display("FAIL snap%0d: got pc=%h rdy=%b en=%b c=%b push=%h lvl=%0d ovf=%b unf=%b; exp pc=%h rdy=%b en=%b c=%b push=%h lvl=%0d ovf=%b unf=%b",
                   n, pc, ready, stk_en, stk_c, stk_push, level, ovf, unf,
                   e.pc, e.rdy, e.en, e.c, e.push, e.lvl, e.ovf, e.unf);
        end
        if (e.chk_peek) begin
          checks++;
          if (stk_peek !== e.peek) begin
            failures++;
            $display("FAIL peek%0d: got %h exp %h", n, stk_peek, e.peek);
          end
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    // Reset held for two edges.
    cyc(0, 0, OP_STEP, 8'h00, mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    cyc(0, 0, OP_STEP, 8'h00, mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    // Step x3.
    cyc(1, 1, OP_STEP, 8'h00, mk(8'h01, 1, 0, 0, 8'h00, 0, 0, 0));
    cyc(1, 1, OP_STEP, 8'h00, mk(8'h02, 1, 0, 0, 8'h00, 0, 0, 0));
    cyc(1, 1, OP_STEP, 8'h00, mk(8'h03, 1, 0, 0, 8'h00, 0, 0, 0));
    // Call/return round trip; a jump offered during ISSUE must be ignored.
    cyc(1, 1, OP_CALL, 8'h40, mk(8'h40, 0, 1, 1, 8'h04, 1, 0, 0));
    cyc(1, 1, OP_JUMP, 8'h99, mk(8'h40, 0, 0, 1, 8'h04, 1, 0, 0));
    cyc(1, 0, OP_STEP, 8'h00, with_peek(mk(8'h40, 1, 0, 1, 8'h04, 1, 0, 0), 8'h04));
    cyc(1, 1, OP_RET,  8'h00, mk(8'h04, 0, 1, 0, 8'h04, 0, 0, 0));
    cyc(1, 0, OP_STEP, 8'h00, mk(8'h04, 0, 0, 0, 8'h04, 0, 0, 0));
    cyc(1, 0, OP_STEP, 8'h00, mk(8'h04, 1, 0, 0, 8'h04, 0, 0, 0));
    // Nesting and overflow.
    cyc(1, 1, OP_JUMP, 8'h10, mk(8'h10, 1, 0, 0, 8'h04, 0, 0, 0));
    cyc(1, 1, OP_CALL, 8'h20, mk(8'h20, 0, 1, 1, 8'h11, 1, 0, 0));
    cyc(1, 0, OP_STEP, 8'h00, mk(8'h20, 0, 0, 1, 8'h11, 1, 0, 0));
    cyc(1, 0, OP_STEP, 8'h00, with_peek(mk(8'h20, 1, 0, 1, 8'h11, 1, 0, 0), 8'h11));
    cyc(1, 1, OP_CALL, 8'h30, mk(8'h30, 0, 1, 1, 8'h21, 2, 0, 0));
    cyc(1, 0, OP_STEP, 8'h00, mk(8'h30, 0, 0, 1, 8'h21, 2, 0, 0));
    cyc(1, 0, OP_STEP, 8'h00, with_peek(mk(8'h30, 1, 0, 1, 8'h21, 2, 0, 0), 8'h21));
    cyc(1, 1, OP_CALL, 8'h50, mk(8'h50, 1, 0, 1, 8'h21, 2, 1, 0));
    cyc(1, 1, OP_RET,  8'h00, mk(8'h21, 0, 1, 0, 8'h21, 1, 1, 0));
    cyc(1, 0, OP_STEP, 8'h00, mk(8'h21, 0, 0, 0, 8'h21, 1, 1, 0));
    cyc(1, 0, OP_STEP, 8'h00, with_peek(mk(8'h21, 1, 0, 0, 8'h21, 1, 1, 0), 8'h11));
    cyc(1, 1, OP_RET,  8'h00, mk(8'h11, 0, 1, 0, 8'h21, 0, 1, 0));
    cyc(1, 0, OP_STEP, 8'h00, mk(8'h11, 0, 0, 0, 8'h21, 0, 1, 0));
    cyc(1, 0, OP_STEP, 8'h00, mk(8'h11, 1, 0, 0, 8'h21, 0, 1, 0));
    // Underflow.
    cyc(1, 1, OP_JUMP, 8'h07, mk(8'h07, 1, 0, 0, 8'h21, 0, 1, 0));
    cyc(1, 1, OP_RET,  8'h00, mk(8'h08, 1, 0, 0, 8'h21, 0, 1, 1));
    cyc(1, 0, OP_STEP, 8'h00, mk(8'h08, 1, 0, 0, 8'h21, 0, 1, 1));
    // Wrap-around of step and of the pushed return address.
    cyc(1, 1, OP_JUMP, 8'hFF, mk(8'hFF, 1, 0, 0, 8'h21, 0, 1, 1));
    cyc(1, 1, OP_STEP, 8'h00, mk(8'h00, 1, 0, 0, 8'h21, 0, 1, 1));
    cyc(1, 1, OP_JUMP, 8'hFF, mk(8'hFF, 1, 0, 0, 8'h21, 0, 1, 1));
    cyc(1, 1, OP_CALL, 8'h10, mk(8'h10, 0, 1, 1, 8'h00, 1, 1, 1));
    cyc(1, 0, OP_STEP, 8'h00, mk(8'h10, 0, 0, 1, 8'h00, 1, 1, 1));
    cyc(1, 0, OP_STEP, 8'h00, with_peek(mk(8'h10, 1, 0, 1, 8'h00, 1, 1, 1), 8'h00));
    // Reset during ISSUE aborts the call; a later ret underflows.
    cyc(1, 1, OP_CALL, 8'h60, mk(8'h60, 0, 1, 1, 8'h11, 2, 1, 1));
    cyc(0, 0, OP_STEP, 8'h00, mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    cyc(1, 0, OP_STEP, 8'h00, mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    cyc(1, 1, OP_RET,  8'h00, mk(8'h01, 1, 0, 0, 8'h00, 0, 0, 1));
    cyc(1, 0, OP_STEP, 8'h00, mk(8'h01, 1, 0, 0, 8'h00, 0, 0, 1));

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d snapshots left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/call_ret_ctrl.md
Name: call_ret_ctrl

Overview:
- Program-counter and call/return sequencer that sits directly upstream of the return-address stack.
- Accepts one control-flow op per handshake (step, jump, call, return) and maintains the PC.
- Drives the stack's control line, enable and push data, and consumes the stack's peek value as the return address.
- Tracks stack occupancy itself, because the stack exposes no full/empty; raises sticky overflow and underflow flags.

Parameters:
- width, 8, PC and return-address width; must equal the stack's width.
- depth, 1, stack pointer bits; stack capacity is 2**depth entries.

Ports:
- clk  input  1  system clock, rising edge
- clr  input  1  global clear; synchronous, active-low
- op_valid  input  1  op request valid
- op  input  2  00 step, 01 jump, 10 call, 11 ret
- target  input  width  jump/call destination
- ready  output  1  op accepted on an edge where op_valid && ready
- pc  output  width  current program counter
- stk_c  output  1  to stack control line: 1 push, 0 pop
- stk_en  output  1  to stack enable
- stk_push  output  width  to stack push data
- stk_peek  input  width  from stack peek (top of stack)
- level  output  depth+1  entries currently on stack, 0..2**depth
- ovf  output  1  sticky: call attempted while level == 2**depth
- unf  output  1  sticky: ret attempted while level == 0

Behaviour:
- All outputs are registered. ready = (state == IDLE).
- Reset: clr sampled low at a rising edge.
  - Sets pc=0, state=IDLE, stk_en=0, stk_c=0, stk_push=0, level=0, ovf=0, unf=0.
  - Reset has priority over everything and aborts ISSUE/SETTLE mid-operation.
  - The stack shares clr, so level=0 stays consistent with it.
- States: IDLE, ISSUE, SETTLE.
- IDLE, no accepted op: hold all outputs; stk_en=0.
- IDLE, step accepted: pc <= pc+1, modulo 2**width; remain in IDLE (single-cycle op).
- IDLE, jump accepted: pc <= target; remain in IDLE.
- IDLE, call accepted, level < 2**depth:
  - Register stk_en=1, stk_c=1, stk_push=pc+1 (wrapped).
  - pc <= target; level <= level+1; go to ISSUE.
- IDLE, call accepted, level == 2**depth:
  - pc <= target; ovf <= 1; no stack op; level unchanged; remain in IDLE.
- IDLE, ret accepted, level > 0:
  - pc <= stk_peek (valid because the stack has been idle for at least one cycle).
  - Register stk_en=1, stk_c=0; level <= level-1; go to ISSUE.
- IDLE, ret accepted, level == 0:
  - pc <= pc+1; unf <= 1; no stack op; remain in IDLE.
- ISSUE: the stack samples en/c/push at this edge. Controller drives stk_en <= 0 and moves to SETTLE.
- SETTLE: one cycle allowing the stack's peek to reflect the new top. Then return to IDLE.
- Latency:
  - call/ret: ready low for exactly 2 cycles after acceptance.
  - step/jump and ovf/unf cases: ready never drops.
- op_valid and op are ignored when ready=0; no queuing.
- stk_push holds its last value when stk_en=0.
- ovf and unf clear only on reset.

Decomposition:
- Shared package holds:
  - op encodings OP_STEP=2'b00, OP_JUMP=2'b01, OP_CALL=2'b10, OP_RET=2'b11
  - state encodings IDLE/ISSUE/SETTLE
- No sub-module is warranted: a single always block for the FSM and datapath.
- The bench instantiates this block together with the stack, sharing clk and clr.

Test Plan (width=8, depth=1, capacity 2):
- Reset and step: hold clr=0 for 2 cycles, release, then step x3 -> pc=0x03, ready=1 throughout, level=0, ovf=unf=0.
- Call/return round trip: at pc=0x03, call target=0x40 -> next edge stk_en=1, stk_c=1, stk_push=0x04, pc=0x40, level=1; ready=0 for 2 cycles. Then ret -> pc=0x04, stk_en=1, stk_c=0 for one cycle, level=0.
- Nesting and overflow:
  - From pc=0x10, call 0x20 and call 0x30 -> level=2, stack peek=0x21.
  - Third call 0x50 -> pc=0x50, ovf=1, no stk_en pulse, ready stays 1.
  - Then ret, ret -> pc=0x21, then pc=0x11.
- Underflow: at level=0, pc=0x07, issue ret -> pc=0x08, unf=1, stk_en never asserted.
- Wrap-around: jump 0xFF, then step -> pc=0x00. Jump 0xFF, then call 0x10 -> stk_push=0x00.
- Reset mid-op: accept a call, drive clr=0 during ISSUE -> next edge pc=0, stk_en=0, level=0, ready=1; a subsequent ret raises unf=1.
